branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch prediction and resolution unit with a direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. Fetch receives a combinational taken/target prediction. EX resolves the branch and drives the pipeline flush mask and redirect address. The unit trains the table on every resolved conditional branch. It sits between the PC/fetch stage and the ID/EX pipeline register.

## Interface
- ADDR_WIDTH, 16, instruction address width
- ENTRIES, 16, BTB entries; power of two, ≥2
- CTR_BITS, 2, saturating counter width, ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetch_pc  in  ADDR_WIDTH  current fetch PC
- predict_taken  out  1  BTB hit and counter MSB set
- predict_target  out  ADDR_WIDTH  stored target for fetch_pc
- ex_jop  in  JUMP_BITS  jump op of instruction in EX
- ex_pc  in  ADDR_WIDTH  PC of instruction in EX
- ex_reg_address  in  ADDR_WIDTH  register target (JR)
- ex_imm_address  in  ADDR_WIDTH  immediate target
- ex_pred_taken  in  1  prediction carried down with the instruction
- zero, less, greater  in  1 each  ALU flags for EX instruction
- flush  out  NUM_PIPE_MASKS  pipe register flush mask
- jump_address  out  ADDR_WIDTH  redirect PC

## Operation
- Index = pc[IW-1:0], IW = log2(ENTRIES). Tag = pc[ADDR_WIDTH-1:IW].
- Entry fields: valid, tag, target, ctr[CTR_BITS-1:0].
- Prediction is combinational. Hit = valid && tag match. predict_taken = hit && ctr MSB. predict_target = entry target; it is 0 when there is no hit.
- Actual taken per jop:
  - JEQ/JZ: zero
  - JNE/JNZ: !zero
  - JL: less
  - JLE: less|zero
  - JG: greater
  - JGE: greater|zero
- Flush mask:
  - NOP: 0
  - J: EX_MEM only
  - JR: FULL = EX_MEM|ID_EX|IF_ID|PC
  - Conditional: FULL when actual ^ ex_pred_taken, otherwise 0
- jump_address:
  - JR: ex_reg_address
  - Conditional mispredict with actual = 0: ex_pc+1 (wraps modulo 2^ADDR_WIDTH)
  - All other cases: ex_imm_address
- Training applies to conditional jops only. J, JR and NOP never touch the table.
  - Hit: ctr saturating +1 if taken, -1 if not taken. Target rewritten with ex_imm_address.
  - Miss and taken: allocate (replace) with valid=1, tag, target=ex_imm_address, ctr = weakly taken (MSB=1, rest 0).
  - Miss and not taken: no write.
- Undefined jop codes are treated as NOP.

## Timing
- Prediction latency: 0 cycles (same cycle as fetch_pc).
- flush and jump_address: combinational from EX inputs, same cycle.
- Table update commits at the rising clk edge of the resolve cycle. It is visible to fetch the following cycle.
- Read/write same index in the same cycle: the read returns the pre-update contents.
- Reset (synchronous, any cycle, including mid-branch):
  - All valid bits and counters are cleared at the edge.
  - While reset is high, predict_taken=0, predict_target=0, flush=0, jump_address=0, and no training occurs.
- Counter saturates at all-ones and at 0; it never wraps.

## Configuration
- BRANCH_PREDICTOR_STATS_EN defined: adds two outputs, stat_branches and stat_mispredicts, each 32 bits.
  - stat_branches increments on each resolved conditional.
  - stat_mispredicts increments on each conditional flush.
  - Both saturate at 2^32-1 and clear on reset.
- Macro undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package: JMP_OP_* codes, JUMP_BITS, PIPE_REG_* masks, NUM_PIPE_MASKS, and a BTB entry typedef.
- One sub-module, btb_table, holds storage, combinational read port, synchronous write port and synchronous clear.
- Resolve and flush logic lives in the top level.

## Test plan
- After reset, fetch_pc=0x0010 → predict_taken=0, predict_target=0.
- JEQ at ex_pc=0x0010, zero=1, ex_pred_taken=0, imm=0x0040 → flush=FULL, jump_address=0x0040. Next cycle, fetch_pc=0x0010 → predict_taken=1, target=0x0040.
- Same branch resolved not taken twice with ex_pred_taken=1 → first resolve gives flush=FULL and jump_address=0x0011, ctr 10→01. Second resolve gives ctr 00 and predict_taken=0.
- JR with ex_reg_address=0x1234 → flush=FULL, jump_address=0x1234, table unchanged. J → flush=EX_MEM only.
- JLE with less=0, zero=1, pred=1 → flush=0. JGE with greater=0, zero=0, pred=0 → flush=0, no allocation.
- Reset asserted in the same cycle as a mispredicting JNE → flush=0, no table write. After release, all entries miss.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared jump-op encodings, pipe-register flush masks and BTB entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_predictor_pkg;

  localparam int JUMP_BITS = 4;

  localparam logic [JUMP_BITS-1:0] JMP_OP_NOP = 4'd0;
  localparam logic [JUMP_BITS-1:0] JMP_OP_J   = 4'd1;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JR  = 4'd2;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JEQ = 4'd3;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JZ  = 4'd4;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JNE = 4'd5;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JNZ = 4'd6;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JL  = 4'd7;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JLE = 4'd8;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JG  = 4'd9;
  localparam logic [JUMP_BITS-1:0] JMP_OP_JGE = 4'd10;

  localparam int NUM_PIPE_MASKS = 4;

  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC     = 4'b0001;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID  = 4'b0010;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX  = 4'b0100;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_EX_MEM = 4'b1000;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_FULL   =
      PIPE_REG_EX_MEM | PIPE_REG_ID_EX | PIPE_REG_IF_ID | PIPE_REG_PC;

  // Default geometry; btb_table mirrors this layout with its own parameter widths.
  localparam int BTB_DEF_ADDR_WIDTH = 16;
  localparam int BTB_DEF_ENTRIES    = 16;
  localparam int BTB_DEF_CTR_BITS   = 2;
  localparam int BTB_DEF_IW         = $clog2(BTB_DEF_ENTRIES);

  typedef struct packed {
    logic                                     valid;
    logic [BTB_DEF_ADDR_WIDTH-BTB_DEF_IW-1:0] tag;
    logic [BTB_DEF_ADDR_WIDTH-1:0]            target;
    logic [BTB_DEF_CTR_BITS-1:0]              ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports, one write port, sync clear.
// Latency: reads 0 cycles; writes visible the cycle after the commit edge.
// Backpressure: none; accepts a write every cycle.
module btb_table #(
  parameter int ADDR_WIDTH = 16,
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2,
  localparam int IW        = $clog2(ENTRIES),
  localparam int TW        = ADDR_WIDTH - IW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IW-1:0]         rd_a_idx,
  output logic                  rd_a_valid,
  output logic [TW-1:0]         rd_a_tag,
  output logic [ADDR_WIDTH-1:0] rd_a_target,
  output logic [CTR_BITS-1:0]   rd_a_ctr,
  input  logic [IW-1:0]         rd_b_idx,
  output logic                  rd_b_valid,
  output logic [TW-1:0]         rd_b_tag,
  output logic [ADDR_WIDTH-1:0] rd_b_target,
  output logic [CTR_BITS-1:0]   rd_b_ctr,
  input  logic                  wr_vld,
  input  logic [IW-1:0]         wr_idx,
  input  logic [TW-1:0]         wr_tag,
  input  logic [ADDR_WIDTH-1:0] wr_target,
  input  logic [CTR_BITS-1:0]   wr_ctr
);

  typedef struct packed {
    logic                  valid;
    logic [TW-1:0]         tag;
    logic [ADDR_WIDTH-1:0] target;
    logic [CTR_BITS-1:0]   ctr;
  } entry_t;

  entry_t mem [ENTRIES];

  assign rd_a_valid  = mem[rd_a_idx].valid;
  assign rd_a_tag    = mem[rd_a_idx].tag;
  assign rd_a_target = mem[rd_a_idx].target;
  assign rd_a_ctr    = mem[rd_a_idx].ctr;

  assign rd_b_valid  = mem[rd_b_idx].valid;
  assign rd_b_tag    = mem[rd_b_idx].tag;
  assign rd_b_target = mem[rd_b_idx].target;
  assign rd_b_ctr    = mem[rd_b_idx].ctr;

  // Tags and targets are don't-care while valid is low, so only valid/ctr are cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].ctr   <= '0;
      end
    end else if (wr_vld) begin
      mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch predict/resolve unit: BTB + saturating counters, EX flush mask and redirect.
// Latency: prediction and resolve outputs combinational; table update at the resolve edge.
// Backpressure: none; one resolve per cycle. Optional BRANCH_PREDICTOR_STATS_EN adds counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = BTB_DEF_ADDR_WIDTH,
  parameter int ENTRIES    = BTB_DEF_ENTRIES,
  parameter int CTR_BITS   = BTB_DEF_CTR_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     fetch_pc,
  output logic                      predict_taken,
  output logic [ADDR_WIDTH-1:0]     predict_target,
  input  logic [JUMP_BITS-1:0]      ex_jop,
  input  logic [ADDR_WIDTH-1:0]     ex_pc,
  input  logic [ADDR_WIDTH-1:0]     ex_reg_address,
  input  logic [ADDR_WIDTH-1:0]     ex_imm_address,
  input  logic                      ex_pred_taken,
  input  logic                      zero,
  input  logic                      less,
  input  logic                      greater,
  output logic [NUM_PIPE_MASKS-1:0] flush,
  output logic [ADDR_WIDTH-1:0]     jump_address
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]               stat_branches,
  output logic [31:0]               stat_mispredicts
`endif
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = ADDR_WIDTH - IW;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_ONE << (CTR_BITS - 1);

  logic                  f_valid, x_valid;
  logic [TW-1:0]         f_tag, x_tag;
  logic [ADDR_WIDTH-1:0] f_target, x_target;
  logic [CTR_BITS-1:0]   f_ctr, x_ctr;
  logic                  f_hit, x_hit;
  logic                  is_cond, actual, mispredict;
  logic                  wr_vld;
  logic [CTR_BITS-1:0]   wr_ctr;

  btb_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ENTRIES    (ENTRIES),
    .CTR_BITS   (CTR_BITS)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .rd_a_idx    (fetch_pc[IW-1:0]),
    .rd_a_valid  (f_valid),
    .rd_a_tag    (f_tag),
    .rd_a_target (f_target),
    .rd_a_ctr    (f_ctr),
    .rd_b_idx    (ex_pc[IW-1:0]),
    .rd_b_valid  (x_valid),
    .rd_b_tag    (x_tag),
    .rd_b_target (x_target),
    .rd_b_ctr    (x_ctr),
    .wr_vld      (wr_vld),
    .wr_idx      (ex_pc[IW-1:0]),
    .wr_tag      (ex_pc[ADDR_WIDTH-1:IW]),
    .wr_target   (ex_imm_address),
    .wr_ctr      (wr_ctr)
  );

  assign f_hit          = f_valid && (f_tag == fetch_pc[ADDR_WIDTH-1:IW]);
  assign predict_taken  = !reset && f_hit && f_ctr[CTR_BITS-1];
  assign predict_target = (!reset && f_hit) ? f_target : '0;

  always_comb begin
    is_cond = 1'b1;
    actual  = 1'b0;
    case (ex_jop)
      JMP_OP_JEQ, JMP_OP_JZ:  actual = zero;
      JMP_OP_JNE, JMP_OP_JNZ: actual = !zero;
      JMP_OP_JL:              actual = less;
      JMP_OP_JLE:             actual = less | zero;
      JMP_OP_JG:              actual = greater;
      JMP_OP_JGE:             actual = greater | zero;
      default:                is_cond = 1'b0;
    endcase
  end

  assign mispredict = is_cond && (actual ^ ex_pred_taken);

  always_comb begin
    flush        = '0;
    jump_address = ex_imm_address;
    if (reset) begin
      jump_address = '0;
    end else if (ex_jop == JMP_OP_J) begin
      flush = PIPE_REG_EX_MEM;
    end else if (ex_jop == JMP_OP_JR) begin
      flush        = PIPE_REG_FULL;
      jump_address = ex_reg_address;
    end else if (mispredict) begin
      flush = PIPE_REG_FULL;
      if (!actual) jump_address = ex_pc + ADDR_WIDTH'(1);
    end
  end

  // Hits always train; a miss only allocates when the branch was actually taken.
  assign x_hit  = x_valid && (x_tag == ex_pc[ADDR_WIDTH-1:IW]);
  assign wr_vld = !reset && is_cond && (x_hit || actual);

  always_comb begin
    wr_ctr = CTR_WEAK;
    if (x_hit) begin
      if (actual) wr_ctr = (&x_ctr) ? x_ctr : x_ctr + CTR_ONE;
      else        wr_ctr = (x_ctr == '0) ? x_ctr : x_ctr - CTR_ONE;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_cond && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: reset, allocation, training, saturation,
// unconditional jumps, condition flags, redirect wrap and reset during a resolve.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [15:0]               fetch_pc;
  logic                      predict_taken;
  logic [15:0]               predict_target;
  logic [JUMP_BITS-1:0]      ex_jop;
  logic [15:0]               ex_pc;
  logic [15:0]               ex_reg_address;
  logic [15:0]               ex_imm_address;
  logic                      ex_pred_taken;
  logic                      zero, less, greater;
  logic [NUM_PIPE_MASKS-1:0] flush;
  logic [15:0]               jump_address;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0]               stat_branches, stat_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_WIDTH(16), .ENTRIES(16), .CTR_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .ex_jop         (ex_jop),
    .ex_pc          (ex_pc),
    .ex_reg_address (ex_reg_address),
    .ex_imm_address (ex_imm_address),
    .ex_pred_taken  (ex_pred_taken),
    .zero           (zero),
    .less           (less),
    .greater        (greater),
    .flush          (flush),
    .jump_address   (jump_address)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic drive_idle();
    ex_jop         = JMP_OP_NOP;
    ex_pc          = 16'h0000;
    ex_reg_address = 16'h0000;
    ex_imm_address = 16'h0000;
    ex_pred_taken  = 1'b0;
    zero           = 1'b0;
    less           = 1'b0;
    greater        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    ex_jop = JMP_OP_JR;
    ex_reg_address = 16'h1234;
    fetch_pc = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++; if (flush !== 4'b0000) begin miscompares++; $display("FAIL rst_flush got %b want 0000", flush); end
    vectors++; if (jump_address !== 16'h0000) begin miscompares++; $display("FAIL rst_jump got %h want 0000", jump_address); end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    vectors++; if (predict_taken !== 1'b0) begin miscompares++; $display("FAIL rst_pred_taken got %b want 0", predict_taken); end
    vectors++; if (predict_target !== 16'h0000) begin miscompares++; $display("FAIL rst_pred_target got %h want 0000", predict_target); end
  endtask

  task automatic test_allocate();
    @(negedge clk);
    ex_jop = JMP_OP_JEQ; ex_pc = 16'h0010; zero = 1'b1; ex_pred_taken = 1'b0;
    ex_imm_address = 16'h0040; fetch_pc = 16'h0010;
    #1;
    vectors++; if (flush !== PIPE_REG_FULL) begin miscompares++; $display("FAIL alloc_flush got %b want 1111", flush); end
    vectors++; if (jump_address !== 16'h0040) begin miscompares++; $display("FAIL alloc_jump got %h want 0040", jump_address); end
    vectors++; if (predict_taken !== 1'b0) begin miscompares++; $display("FAIL alloc_same_cycle_pred got %b want 0", predict_taken); end
    @(negedge clk);
    drive_idle();
    #1;
    vectors++; if (predict_taken !== 1'b1) begin miscompares++; $display("FAIL alloc_pred_taken got %b want 1", predict_taken); end
    vectors++; if (predict_target !== 16'h0040) begin miscompares++; $display("FAIL alloc_pred_target got %h want 0040", predict_target); end
    fetch_pc = 16'h0020;
    #1;
    vectors++; if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin miscompares++; $display("FAIL tag_miss got %b/%h want 0/0000", predict_taken, predict_target); end
    fetch_pc = 16'h0010;
  endtask

  task automatic test_train_down();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      ex_jop = JMP_OP_JEQ; ex_pc = 16'h0010; zero = 1'b0; ex_pred_taken = 1'b1;
      ex_imm_address = 16'h0040;
      #1;
      vectors++; if (flush !== PIPE_REG_FULL) begin miscompares++; $display("FAIL down%0d_flush got %b want 1111", r, flush); end
      vectors++; if (jump_address !== 16'h0011) begin miscompares++; $display("FAIL down%0d_jump got %h want 0011", r, jump_address); end
      @(negedge clk);
      drive_idle();
      #1;
      vectors++; if (predict_taken !== 1'b0) begin miscompares++; $display("FAIL down%0d_pred got %b want 0", r, predict_taken); end
      vectors++; if (predict_target !== 16'h0040) begin miscompares++; $display("FAIL down%0d_target got %h want 0040", r, predict_target); end
    end
  endtask

  // Counter starts at 00: taken x4 (01,10,11,11), then not-taken x2 (10,01).
  task automatic test_saturation();
    logic [5:0] zs, ps, fs, as;
    logic [15:0] exp_jump;
    zs = 6'b001111;
    ps = 6'b111100;
    fs = 6'b110011;
    as = 6'b011110;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ex_jop = JMP_OP_JZ; ex_pc = 16'h0010; zero = zs[i]; ex_pred_taken = ps[i];
      ex_imm_address = 16'h0040;
      exp_jump = zs[i] ? 16'h0040 : 16'h0011;
      #1;
      vectors++; if (flush !== (fs[i] ? PIPE_REG_FULL : 4'b0000)) begin miscompares++; $display("FAIL sat%0d_flush got %b want %b", i, flush, fs[i] ? PIPE_REG_FULL : 4'b0000); end
      vectors++; if (jump_address !== exp_jump) begin miscompares++; $display("FAIL sat%0d_jump got %h want %h", i, jump_address, exp_jump); end
      @(negedge clk);
      drive_idle();
      #1;
      vectors++; if (predict_taken !== as[i]) begin miscompares++; $display("FAIL sat%0d_pred got %b want %b", i, predict_taken, as[i]); end
    end
  endtask

  task automatic test_uncond();
    @(negedge clk);
    ex_jop = JMP_OP_JR; ex_pc = 16'h0010; ex_reg_address = 16'h1234;
    ex_imm_address = 16'h0999; zero = 1'b1;
    #1;
    vectors++; if (flush !== PIPE_REG_FULL) begin miscompares++; $display("FAIL jr_flush got %b want 1111", flush); end
    vectors++; if (jump_address !== 16'h1234) begin miscompares++; $display("FAIL jr_jump got %h want 1234", jump_address); end
    @(negedge clk);
    ex_jop = JMP_OP_J;
    #1;
    vectors++; if (flush !== PIPE_REG_EX_MEM) begin miscompares++; $display("FAIL j_flush got %b want 1000", flush); end
    vectors++; if (jump_address !== 16'h0999) begin miscompares++; $display("FAIL j_jump got %h want 0999", jump_address); end
    @(negedge clk);
    drive_idle();
    #1;
    vectors++; if (predict_target !== 16'h0040 || predict_taken !== 1'b0) begin miscompares++; $display("FAIL uncond_no_train got %b/%h want 0/0040", predict_taken, predict_target); end
  endtask

  task automatic test_cond_flags();
    @(negedge clk);
    ex_jop = JMP_OP_JLE; ex_pc = 16'h0030; less = 1'b0; zero = 1'b1;
    ex_pred_taken = 1'b1; ex_imm_address = 16'h0050;
    #1;
    vectors++; if (flush !== 4'b0000) begin miscompares++; $display("FAIL jle_flush got %b want 0000", flush); end
    @(negedge clk);
    drive_idle();
    ex_jop = JMP_OP_JGE; ex_pc = 16'h0025; ex_imm_address = 16'h0060;
    #1;
    vectors++; if (flush !== 4'b0000) begin miscompares++; $display("FAIL jge_flush got %b want 0000", flush); end
    vectors++; if (jump_address !== 16'h0060) begin miscompares++; $display("FAIL jge_jump got %h want 0060", jump_address); end
    @(negedge clk);
    drive_idle();
    fetch_pc = 16'h0025;
    #1;
    vectors++; if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin miscompares++; $display("FAIL jge_no_alloc got %b/%h want 0/0000", predict_taken, predict_target); end
    fetch_pc = 16'h0030;
    #1;
    vectors++; if (predict_taken !== 1'b1 || predict_target !== 16'h0050) begin miscompares++; $display("FAIL jle_alloc got %b/%h want 1/0050", predict_taken, predict_target); end
    ex_jop = JMP_OP_JL; ex_pc = 16'h0040; less = 1'b1; ex_imm_address = 16'h0070;
    #1;
    vectors++; if (flush !== PIPE_REG_FULL || jump_address !== 16'h0070) begin miscompares++; $display("FAIL jl got %b/%h want 1111/0070", flush, jump_address); end
    @(negedge clk);
    drive_idle();
    ex_jop = JMP_OP_JG; ex_pc = 16'h0041; ex_pred_taken = 1'b1; ex_imm_address = 16'h0070;
    #1;
    vectors++; if (flush !== PIPE_REG_FULL || jump_address !== 16'h0042) begin miscompares++; $display("FAIL jg got %b/%h want 1111/0042", flush, jump_address); end
    @(negedge clk);
    drive_idle();
    ex_jop = 4'hF; ex_pc = 16'h0026; zero = 1'b1; ex_pred_taken = 1'b1; ex_imm_address = 16'h0077;
    #1;
    vectors++; if (flush !== 4'b0000 || jump_address !== 16'h0077) begin miscompares++; $display("FAIL undef_op got %b/%h want 0000/0077", flush, jump_address); end
    @(negedge clk);
    drive_idle();
    fetch_pc = 16'h0026;
    ex_jop = JMP_OP_JNZ; ex_pc = 16'hFFFF; zero = 1'b1; ex_pred_taken = 1'b1; ex_imm_address = 16'h0088;
    #1;
    vectors++; if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin miscompares++; $display("FAIL undef_no_train got %b/%h want 0/0000", predict_taken, predict_target); end
    vectors++; if (flush !== PIPE_REG_FULL || jump_address !== 16'h0000) begin miscompares++; $display("FAIL wrap got %b/%h want 1111/0000", flush, jump_address); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    ex_jop = JMP_OP_JNE; ex_pc = 16'h0050; zero = 1'b0; ex_pred_taken = 1'b0;
    ex_imm_address = 16'h0080; fetch_pc = 16'h0030;
    #1;
    vectors++; if (flush !== 4'b0000 || jump_address !== 16'h0000) begin miscompares++; $display("FAIL midrst_resolve got %b/%h want 0000/0000", flush, jump_address); end
    vectors++; if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin miscompares++; $display("FAIL midrst_pred got %b/%h want 0/0000", predict_taken, predict_target); end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    fetch_pc = 16'h0050;
    #1;
    vectors++; if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin miscompares++; $display("FAIL midrst_no_write got %b/%h want 0/0000", predict_taken, predict_target); end
    fetch_pc = 16'h0030;
    #1;
    vectors++; if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin miscompares++; $display("FAIL midrst_cleared got %b/%h want 0/0000", predict_taken, predict_target); end
    fetch_pc = 16'h0010;
    #1;
    vectors++; if (predict_target !== 16'h0000) begin miscompares++; $display("FAIL midrst_cleared10 got %h want 0000", predict_target); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_train_down();
    test_saturation();
    test_uncond();
    test_cond_flags();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
